// File: rtl/m4_rr_arbiter.sv
// -----------------------------------------------------------------------------
// m4_rr_arbiter
//
// Round-robin arbiter in front of the m4 4:1 mux. It is the only driver of the
// mux select lines, so the granted source is the one that appears on m4.out.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset (synchronous release upstream)
//   req_i[3:0] level requests, req_i[k] -> m4 input i(k+1), held until served
//   gnt_o[3:0] registered one-hot grant, or all zero when the mux is unowned
//   sel1_o     registered m4 select LSB (1 selects i2/i4)
//   sel2_o     registered m4 select MSB (1 selects i3/i4)
//   gnt_vld_o  registered, high while any grant bit is set
//
// Parameter:
//   HOLD_CYCLES  max consecutive cycles one owner keeps the grant while others
//                wait; legal range 1..255. Only used with the macro below.
//
// Build option:
//   M4_ARB_HOLD_LIMIT_EN  when defined, an owner that has held the grant for
//                         HOLD_CYCLES cycles is pre-empted if anyone else is
//                         waiting. When undefined, no hold counter exists and
//                         the owner keeps the grant until its request drops.
// -----------------------------------------------------------------------------
module m4_rr_arbiter #(
   parameter int unsigned HOLD_CYCLES = 16
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic [3:0] req_i,
   output logic [3:0] gnt_o,
   output logic       sel1_o,
   output logic       sel2_o,
   output logic       gnt_vld_o
);

   typedef enum logic [0:0] {StIdle, StOwn} state_e;

   state_e     state_q, state_d;
   logic [3:0] gnt_q, gnt_d;
   logic [1:0] sel_q, sel_d;
   logic [1:0] last_q, last_d;

   logic [3:0] others;
   logic [1:0] pick_idx;
   logic       take_over;

   if (HOLD_CYCLES < 1 || HOLD_CYCLES > 255) begin : g_bad_hold
      $error("m4_rr_arbiter: HOLD_CYCLES must be in 1..255");
   end

   // First set bit of mask scanning upward from last+1 with wrap. The loop runs
   // from lowest priority (last itself) to highest so the final write wins.
   function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] last);
      logic [1:0] idx;
      rr_pick = last;
      for (int i = 4; i >= 1; i--) begin
         idx = last + 2'(i);
         if (mask[idx]) begin
            rr_pick = idx;
         end
      end
   endfunction

   // In IDLE gnt_q is zero, so one picker serves both the initial grant and
   // handover. The current owner is never a candidate for its own handover.
   assign others   = req_i & ~gnt_q;
   assign pick_idx = rr_pick(others, last_q);

`ifdef M4_ARB_HOLD_LIMIT_EN
   logic [7:0] hold_cnt_q, hold_cnt_d;
   logic       hold_expired;

   // >= rather than == so a requester arriving after saturation still pre-empts.
   assign hold_expired = (hold_cnt_q >= 8'(HOLD_CYCLES - 1));
`endif

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      sel_d     = sel_q;
      last_d    = last_q;
      take_over = 1'b0;
`ifdef M4_ARB_HOLD_LIMIT_EN
      hold_cnt_d = hold_cnt_q;
`endif

      case (state_q)
         StIdle: begin
            if (|req_i) begin
               take_over = 1'b1;
            end
         end
         StOwn: begin
            if (|(req_i & gnt_q)) begin
`ifdef M4_ARB_HOLD_LIMIT_EN
               if (hold_expired && |others) begin
                  take_over = 1'b1;
               end else if (hold_cnt_q < 8'(HOLD_CYCLES)) begin
                  hold_cnt_d = hold_cnt_q + 8'd1;
               end
`endif
            end else if (|others) begin
               take_over = 1'b1;
            end else begin
               // sel is left alone so the mux output stays stable while idle
               state_d = StIdle;
               gnt_d   = '0;
            end
         end
         default: begin
            state_d = StIdle;
            gnt_d   = '0;
         end
      endcase

      if (take_over) begin
         state_d = StOwn;
         gnt_d   = 4'b0001 << pick_idx;
         sel_d   = pick_idx;
         last_d  = pick_idx;
`ifdef M4_ARB_HOLD_LIMIT_EN
         hold_cnt_d = '0;
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         gnt_q   <= '0;
         sel_q   <= '0;
         last_q  <= 2'd3;
`ifdef M4_ARB_HOLD_LIMIT_EN
         hold_cnt_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
`ifdef M4_ARB_HOLD_LIMIT_EN
         hold_cnt_q <= hold_cnt_d;
`endif
      end
   end

   assign gnt_o     = gnt_q;
   assign sel1_o    = sel_q[0];
   assign sel2_o    = sel_q[1];
   assign gnt_vld_o = (state_q == StOwn);

endmodule

// File: tb/tb_m4_rr_arbiter.sv
// Bench for m4_rr_arbiter: directed scenarios plus a random run, all checked
// against a behavioural round-robin model through a scoreboard queue.
module tb_m4_rr_arbiter;

   localparam int unsigned Hold = 4;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] req   = 4'b0000;
   logic [3:0] gnt;
   logic       sel1;
   logic       sel2;
   logic       gnt_vld;

   always #5 clk = ~clk;

   m4_rr_arbiter #(
      .HOLD_CYCLES(Hold)
   ) u_dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .req_i    (req),
      .gnt_o    (gnt),
      .sel1_o   (sel1),
      .sel2_o   (sel2),
      .gnt_vld_o(gnt_vld)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct packed {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       vld;
   } exp_t;

   exp_t sb[$];
   int   m_own  = -1;
   int   m_last = 3;
   int   m_sel  = 0;
   int   m_cnt  = 0;

   function automatic int scan(input logic [3:0] r, input int from);
      for (int k = 1; k <= 4; k++) begin
         if (r[(from + k) % 4]) return (from + k) % 4;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_own  = -1;
      m_last = 3;
      m_sel  = 0;
      m_cnt  = 0;
      sb.delete();
   endtask

   task automatic model_step(input logic [3:0] r);
      int   nxt;
      exp_t e;
      nxt = -1;
      if (m_own < 0) begin
         nxt = scan(r, m_last);
      end else if (r[m_own]) begin
`ifdef M4_ARB_HOLD_LIMIT_EN
         if (m_cnt >= Hold - 1) nxt = scan(r & ~(4'b0001 << m_own), m_own);
`endif
         if (nxt < 0 && m_cnt < Hold) m_cnt++;
      end else begin
         nxt = scan(r, m_own);
         if (nxt < 0) m_own = -1;
      end
      if (nxt >= 0) begin
         m_own  = nxt;
         m_last = nxt;
         m_sel  = nxt;
         m_cnt  = 0;
      end
      e.gnt = (m_own < 0) ? 4'b0000 : (4'b0001 << m_own);
      e.sel = 2'(m_sel);
      e.vld = (m_own >= 0);
      sb.push_back(e);
   endtask

   // Drive one request vector, let one edge pass, compare against the model.
   task automatic step(input logic [3:0] r);
      exp_t e;
      @(negedge clk);
      req = r;
      model_step(r);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check_eq("sb_empty", 32'd1, 32'd0);
      end else begin
         e = sb.pop_front();
         check_eq("gnt", gnt, e.gnt);
         check_eq("sel", {sel2, sel1}, e.sel);
         check_eq("vld", gnt_vld, e.vld);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      req   = 4'b0000;
      rst_n = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   logic [3:0] order_req [9] = '{4'hF, 4'hF, 4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7};
   logic [3:0] order_gnt [9] = '{4'h1, 4'h1, 4'h2, 4'h2, 4'h4, 4'h4, 4'h8, 4'h8, 4'h1};
   logic [1:0] order_sel [9] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};

   initial begin
      int         wait_cnt[4];
      logic [3:0] prev_gnt;
      logic [3:0] r;

      // reset values
      #12;
      check_eq("rst_gnt", gnt, 4'b0000);
      check_eq("rst_vld", gnt_vld, 1'b0);
      check_eq("rst_sel", {sel2, sel1}, 2'b00);
      @(negedge clk);
      rst_n = 1'b1;

      // single request, one-cycle latency, sel held after release
      step(4'b0001);
      check_eq("t1_gnt", gnt, 4'b0001);
      check_eq("t1_vld", gnt_vld, 1'b1);
      check_eq("t1_sel", {sel2, sel1}, 2'b00);
      step(4'b0000);
      check_eq("t1_idle_gnt", gnt, 4'b0000);
      check_eq("t1_idle_sel", {sel2, sel1}, 2'b00);

      // full rotation with no idle gap
      apply_reset();
      for (int k = 0; k < 9; k++) begin
         step(order_req[k]);
         check_eq("rot_gnt", gnt, order_gnt[k]);
         check_eq("rot_sel", {sel2, sel1}, order_sel[k]);
      end

      // handover from idx2 wraps past empty idx3 and idx0
      apply_reset();
      step(4'b0100);
      check_eq("wrap_own", gnt, 4'b0100);
      step(4'b0010);
      check_eq("wrap_gnt", gnt, 4'b0010);
      check_eq("wrap_sel", {sel2, sel1}, 2'b01);

      // hold limit
      apply_reset();
      step(4'b0001);
      for (int k = 0; k < 3; k++) begin
         step(4'b0011);
         check_eq("hold_keep", gnt, 4'b0001);
      end
      step(4'b0011);
`ifdef M4_ARB_HOLD_LIMIT_EN
      check_eq("hold_preempt", gnt, 4'b0010);
`else
      check_eq("hold_nolimit", gnt, 4'b0001);
      step(4'b0010);
      check_eq("hold_drop", gnt, 4'b0010);
`endif

      // async reset mid-grant
      apply_reset();
      step(4'b1000);
      check_eq("ar_own", gnt, 4'b1000);
      @(negedge clk);
      #2;
      req   = 4'b0000;
      rst_n = 1'b0;
      #1;
      check_eq("ar_gnt", gnt, 4'b0000);
      check_eq("ar_vld", gnt_vld, 1'b0);
      check_eq("ar_sel", {sel2, sel1}, 2'b00);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      step(4'b1111);
      check_eq("ar_first", gnt, 4'b0001);

      // random run with invariant and starvation checks
      apply_reset();
      for (int i = 0; i < 4; i++) wait_cnt[i] = 0;
      prev_gnt = 4'b0000;
      for (int c = 0; c < 10000; c++) begin
         r = req;
         for (int i = 0; i < 4; i++) begin
            if (m_own == i) begin
               if ($urandom_range(2) == 0) r[i] = 1'b0;
            end else if (!r[i]) begin
               r[i] = 1'($urandom_range(1));
            end
         end
         step(r);
         check_eq("onehot0", $onehot0(gnt), 1'b1);
         check_eq("vld_or", gnt_vld, |gnt);
         if (gnt_vld) begin
            check_eq("sel_idx", 4'b0001 << {sel2, sel1}, gnt);
         end
         if (gnt != prev_gnt && gnt != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
               if (gnt[i]) wait_cnt[i] = 0;
               else if (req[i]) wait_cnt[i]++;
               check_eq("starve", wait_cnt[i] > 3, 1'b0);
            end
         end
         prev_gnt = gnt;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
